// File: rtl/pll_reset_sequencer.sv
// Lock-qualified PLL reset sequencer: owns the PLL reset, waits for stable lock, then releases
// staged active-low downstream resets. Optional lock-loss counter: PLL_RESET_SEQ_LOSS_COUNT_EN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 100000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int NUM_STAGES         = 4,
  parameter int STAGE_GAP          = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  ready
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0]            lock_loss_count
`endif
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_STAGES-1:0]  rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
  assign idx_nxt = idx_q + IDX_W'(1);

  // NOTE: every state register updates with <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_n_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      rst_n_q   <= rst_n_d;
      ready_q   <= ready_d;
    end
  end

  // NOTE: hold-by-default assignments first keep this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pll_rst_d = pll_rst_q;
    rst_n_d   = rst_n_q;
    ready_d   = ready_q;
    case (state_q)
      PLL_RESET: begin
        pll_rst_d = 1'b1;
        rst_n_d   = '0;
        ready_d   = 1'b0;
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d   = PLL_RESET;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = NUM_STAGES'(1);
          if (NUM_STAGES == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE, RUN: begin
        // Lock loss takes priority over a software re-sequence request.
        if (!lock_s) begin
          state_d   = PLL_RESET;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          rst_n_d   = '0;
          ready_d   = 1'b0;
        end else if (sw_reset_req) begin
          state_d = STABLE;
          cnt_d   = '0;
          rst_n_d = '0;
          ready_d = 1'b0;
        end else if (state_q == RELEASE) begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_d   = '0;
            idx_d   = idx_nxt;
            rst_n_d = rst_n_q | (NUM_STAGES'(1) << idx_nxt);
            if (idx_nxt == IDX_W'(NUM_STAGES - 1)) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = PLL_RESET;
    endcase
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out_n = rst_n_q;
  assign ready     = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;
  logic       loss_evt;

  assign loss_evt = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumes the audio PLL's `locked` status and owns the PLL's `rst` input.
- Produces staged, lock-qualified active-low resets for the logic clocked by the four PLL outputs (100/50/10/5 MHz).
- Runs on the free-running 100 MHz reference clock, never on a PLL output, so it keeps working while the PLL is unlocked.
- Retries the PLL on lock timeout and tears down all downstream resets on lock loss.

Parameters:
SYNC_STAGES, 2, flops in the `pll_locked` synchronizer (minimum 2)
PLL_RST_CYCLES, 16, cycles `pll_rst` is held high per attempt (minimum 1)
LOCK_TIMEOUT, 100000, cycles to wait for lock before retrying the PLL
LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before release
NUM_STAGES, 4, number of staged reset outputs
STAGE_GAP, 8, cycles between successive stage releases (minimum 1)

Ports:
clk  input  1  free-running reference clock (100 MHz)
reset_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL lock status, asynchronous to `clk`
sw_reset_req  input  1  synchronous single-cycle request to re-sequence downstream resets without resetting the PLL
pll_rst  output  1  active-high reset to the PLL
rst_out_n  output  NUM_STAGES  active-low downstream resets; bit 0 released first
ready  output  1  high when all stages are released and lock is good
lock_loss_count  output  8  lock-loss event counter (present only with the optional feature)

Behaviour:
- Reset is fixed: one clock `clk`; `reset_n` is asynchronous assert, active-low.
- Values while `reset_n`=0:
  - `pll_rst`=1, `rst_out_n`=all 0, `ready`=0, `lock_loss_count`=0.
  - Synchronizer flops cleared to 0.
  - State = PLL_RESET, all counters 0.
- `pll_locked` passes through a SYNC_STAGES flop chain; `lock_s` denotes the synchronized value (latency SYNC_STAGES cycles). All decisions use `lock_s` only.
- Counters are sized with `$clog2(max value + 1)`. They saturate and never wrap.
- States:
  - PLL_RESET:
    - `pll_rst`=1; count PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
    - `rst_out_n` held all 0.
  - WAIT_LOCK:
    - `pll_rst`=0.
    - If `lock_s`=1, go to STABLE with the stable counter at 0.
    - If LOCK_TIMEOUT cycles elapse without lock, go to PLL_RESET (retry, unbounded).
  - STABLE:
    - Count consecutive cycles of `lock_s`=1.
    - Any `lock_s`=0 returns to WAIT_LOCK; the timeout counter restarts at 0.
    - On reaching LOCK_STABLE_CYCLES, go to RELEASE with stage index 0.
  - RELEASE:
    - On entry cycle, `rst_out_n[0]` goes high.
    - Each further STAGE_GAP cycles releases the next bit, in order.
    - After releasing bit NUM_STAGES-1, go to RUN.
    - Released bits stay high.
  - RUN: `ready`=1. This is the only state with `ready` high.
- Lock loss (`lock_s`=0 while in RELEASE or RUN):
  - Next edge: `rst_out_n`=all 0, `ready`=0, go to PLL_RESET.
  - This counts one lock-loss event.
- `sw_reset_req`=1 in RELEASE or RUN with `lock_s`=1:
  - Next edge: `rst_out_n`=all 0, `ready`=0, go to STABLE with its counter at 0.
  - `pll_rst` is not asserted.
  - Ignored in PLL_RESET, WAIT_LOCK and STABLE.
- Simultaneous lock loss and `sw_reset_req`: lock loss wins.
- Outputs are registered; all `rst_out_n` bits assert on the same edge.
- `reset_n` asserted mid-sequence restarts everything from PLL_RESET immediately (asynchronous).

Optional Feature:
- Macro: `PLL_RESET_SEQ_LOSS_COUNT_EN`.
- Defined:
  - `lock_loss_count` port exists.
  - Increments by 1 per lock-loss event (RELEASE/RUN to PLL_RESET), saturating at 255.
  - Cleared only by `reset_n`.
  - Timeouts in WAIT_LOCK and `sw_reset_req` do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE_CYCLES=10, NUM_STAGES=4, STAGE_GAP=3.
1. Power-up: deassert `reset_n`; `pll_locked`=1 from cycle 20.
   -> `pll_rst` high exactly 4 cycles.
   -> `rst_out_n[0]` rises 2+10 cycles after lock, then bits 1, 2, 3 at +3, +6, +9.
   -> `ready`=1 on the same edge as bit 3.
2. Lock timeout: `pll_locked` held 0.
   -> `pll_rst` re-pulses for 4 cycles every 54 cycles; `rst_out_n` stays 0.
3. Lock glitch in STABLE: `locked` drops 1 cycle after 7 locked cycles.
   -> Stable count restarts.
   -> First release occurs 10 cycles after the final re-lock (plus sync latency).
4. Lock loss in RUN: drop `pll_locked` at cycle 200.
   -> `rst_out_n`=0000 and `ready`=0 exactly 3 edges later (2 sync + 1).
   -> `pll_rst` asserts; `lock_loss_count`=1 with the feature enabled.
5. `sw_reset_req` pulse in RUN, PLL locked.
   -> `rst_out_n`=0000 next edge, `pll_rst` stays 0.
   -> Re-release after 10 cycles; `lock_loss_count` unchanged.
6. `reset_n` asserted mid-RELEASE (2 bits released).
   -> All outputs reach reset values asynchronously.
   -> Full sequence from scenario 1 repeats after deassertion.
